// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control FSM: opcodes, states,
// datapath mux codes and the packed control word driven onto the datapath.
package mc_ctrl_pkg;

   localparam int unsigned OP_W = 4;

   localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
   localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
   localparam logic [OP_W-1:0] OP_AND  = 4'b0111;
   localparam logic [OP_W-1:0] OP_ADDI = 4'b0011;
   localparam logic [OP_W-1:0] OP_LW   = 4'b1000;
   localparam logic [OP_W-1:0] OP_SW   = 4'b1010;
   localparam logic [OP_W-1:0] OP_BEQ  = 4'b1110;
   localparam logic [OP_W-1:0] OP_HALT = 4'b1111;

   typedef enum logic [3:0] {
      ST_RST    = 4'd0,
      ST_FETCH  = 4'd1,
      ST_DECODE = 4'd2,
      ST_EXEC_R = 4'd3,
      ST_WB_R   = 4'd4,
      ST_EXEC_I = 4'd5,
      ST_WB_I   = 4'd6,
      ST_ADDR   = 4'd7,
      ST_MEM_RD = 4'd8,
      ST_WB_MEM = 4'd9,
      ST_MEM_WR = 4'd10,
      ST_BRANCH = 4'd11,
      ST_HALT   = 4'd12
   } state_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010
   } alu_op_e;

   typedef enum logic [1:0] {
      PC_ALU    = 2'b00,
      PC_ALUOUT = 2'b01,
      PC_JUMP   = 2'b10
   } pc_src_e;

   typedef enum logic [1:0] {
      SRCB_RT  = 2'b00,
      SRCB_ONE = 2'b01,
      SRCB_IMM = 2'b10
   } alu_src_b_e;

   typedef struct packed {
      logic       mem_re;
      logic       mem_we;
      logic       iord;
      logic       ir_we;
      logic       pc_we;
      pc_src_e    pc_src;
      logic       reg_we;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      alu_src_b_e alu_src_b;
      alu_op_e    alu_op;
   } ctrl_t;

   // ALU operation for an R-type opcode; anything else falls back to ADD.
   function automatic alu_op_e r_alu_op(input logic [OP_W-1:0] op);
      case (op)
         OP_SUB:  return ALU_SUB;
         OP_AND:  return ALU_AND;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decode from the registered FSM state, with the
// FETCH writes qualified by mem_ready and the BRANCH PC write by zero.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  state_e          state_i,
   input  logic [OP_W-1:0] opcode_i,
   input  logic            mem_ready_i,
   input  logic            zero_i,
   output ctrl_t           ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         ST_FETCH: begin
            ctrl_o.mem_re    = 1'b1;
            ctrl_o.alu_src_b = SRCB_ONE;
            ctrl_o.alu_op    = ALU_ADD;
            ctrl_o.pc_src    = PC_ALU;
            ctrl_o.ir_we     = mem_ready_i;
            ctrl_o.pc_we     = mem_ready_i;
         end
         ST_DECODE: begin
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALU_ADD;
         end
         ST_EXEC_R: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_RT;
            ctrl_o.alu_op    = r_alu_op(opcode_i);
         end
         ST_WB_R: begin
            ctrl_o.reg_we  = 1'b1;
            ctrl_o.reg_dst = 1'b1;
         end
         ST_EXEC_I, ST_ADDR: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALU_ADD;
         end
         ST_WB_I: begin
            ctrl_o.reg_we = 1'b1;
         end
         ST_MEM_RD: begin
            ctrl_o.mem_re = 1'b1;
            ctrl_o.iord   = 1'b1;
         end
         ST_WB_MEM: begin
            ctrl_o.reg_we     = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
         end
         ST_MEM_WR: begin
            ctrl_o.mem_we = 1'b1;
            ctrl_o.iord   = 1'b1;
         end
         ST_BRANCH: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_RT;
            ctrl_o.alu_op    = ALU_SUB;
            ctrl_o.pc_src    = PC_ALUOUT;
            ctrl_o.pc_we     = zero_i;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle sequencer for the 4-bit-opcode datapath: FSM, memory wait
// timeout, sticky status flags and the saturating retired-instruction counter.
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [OP_W-1:0]  OPCODE,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_re,
   output logic             mem_we,
   output logic             iord,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_src,
   output logic             reg_we,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_op,
   output logic             halted,
   output logic             illegal,
   output logic             bus_err,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              halted_q, halted_d;
   logic              illegal_q, illegal_d;
   logic              bus_err_q, bus_err_d;
   logic              retire;
   logic              in_mem_state;
   ctrl_t             ctrl_c;

   mc_ctrl_decode u_decode (
      .state_i     (state_q),
      .opcode_i    (OPCODE),
      .mem_ready_i (mem_ready),
      .zero_i      (zero),
      .ctrl_o      (ctrl_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RST;
         wait_q    <= '0;
         cnt_q     <= '0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         cnt_q     <= cnt_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign in_mem_state = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) ||
                         (state_q == ST_MEM_WR);

   always_comb begin
      state_d   = state_q;
      wait_d    = '0;
      retire    = 1'b0;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      case (state_q)
         ST_RST:    state_d = ST_FETCH;
         ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
         ST_DECODE: begin
            case (OPCODE)
               OP_ADD, OP_SUB, OP_AND: state_d = ST_EXEC_R;
               OP_ADDI:                state_d = ST_EXEC_I;
               OP_LW, OP_SW:           state_d = ST_ADDR;
               OP_BEQ:                 state_d = ST_BRANCH;
               OP_HALT:                state_d = ST_HALT;
               default: begin
                  state_d   = ST_FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         ST_EXEC_R: state_d = ST_WB_R;
         ST_EXEC_I: state_d = ST_WB_I;
         ST_ADDR:   state_d = (OPCODE == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
         ST_MEM_RD: if (mem_ready) state_d = ST_WB_MEM;
         ST_MEM_WR: begin
            if (mem_ready) begin
               state_d = ST_FETCH;
               retire  = 1'b1;
            end
         end
         ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH: begin
            state_d = ST_FETCH;
            retire  = 1'b1;
         end
         ST_HALT:   state_d = ST_HALT;
         default:   state_d = ST_RST;
      endcase

      // The WAIT_MAX-th consecutive not-ready cycle times out; ready on that cycle still completes.
      if (in_mem_state && !mem_ready) begin
         if (wait_q == WAIT_W'(WAIT_MAX - 1)) begin
            state_d   = ST_HALT;
            bus_err_d = 1'b1;
         end else begin
            wait_d = wait_q + WAIT_W'(1);
         end
      end
   end

   assign halted_d = halted_q | (state_d == ST_HALT);
   assign cnt_d    = (retire && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

   assign mem_re     = ctrl_c.mem_re;
   assign mem_we     = ctrl_c.mem_we;
   assign iord       = ctrl_c.iord;
   assign ir_we      = ctrl_c.ir_we;
   assign pc_we      = ctrl_c.pc_we;
   assign pc_src     = ctrl_c.pc_src;
   assign reg_we     = ctrl_c.reg_we;
   assign reg_dst    = ctrl_c.reg_dst;
   assign mem_to_reg = ctrl_c.mem_to_reg;
   assign alu_src_a  = ctrl_c.alu_src_a;
   assign alu_src_b  = ctrl_c.alu_src_b;
   assign alu_op     = ctrl_c.alu_op;
   assign halted     = halted_q;
   assign illegal    = illegal_q;
   assign bus_err    = bus_err_q;
   assign instr_cnt  = cnt_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Cycle-by-cycle vector bench for mc_ctrl_fsm; a narrow counter width makes
// the saturation point reachable within the instruction sequence.
module tb_mc_ctrl_fsm;

   localparam int unsigned TB_CNT_W = 3;

   logic                clk;
   logic                rst_n;
   logic [3:0]          OPCODE;
   logic                zero;
   logic                mem_ready;
   logic                mem_re, mem_we, iord, ir_we, pc_we;
   logic [1:0]          pc_src;
   logic                reg_we, reg_dst, mem_to_reg, alu_src_a;
   logic [1:0]          alu_src_b;
   logic [2:0]          alu_op;
   logic                halted, illegal, bus_err;
   logic [TB_CNT_W-1:0] instr_cnt;

   mc_ctrl_fsm #(.CNT_W(TB_CNT_W), .WAIT_MAX(15)) dut (
      .clk(clk), .rst_n(rst_n), .OPCODE(OPCODE), .zero(zero), .mem_ready(mem_ready),
      .mem_re(mem_re), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
      .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .halted(halted), .illegal(illegal), .bus_err(bus_err), .instr_cnt(instr_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] cw(input logic re, we, io, irw, pcw, input logic [1:0] pcs,
                                      input logic rw, rd, m2r, sa, input logic [1:0] sb,
                                      input logic [2:0] op);
      return {re, we, io, irw, pcw, pcs, rw, rd, m2r, sa, sb, op};
   endfunction

   localparam logic [15:0] C_ZERO    = 16'h0000;
   localparam logic [15:0] C_FRDY    = cw(1, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 2'b01, 3'b000);
   localparam logic [15:0] C_FWAIT   = cw(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 3'b000);
   localparam logic [15:0] C_DEC     = cw(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 3'b000);
   localparam logic [15:0] C_EXR_ADD = cw(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 3'b000);
   localparam logic [15:0] C_EXR_SUB = cw(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 3'b001);
   localparam logic [15:0] C_EXR_AND = cw(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 3'b010);
   localparam logic [15:0] C_WBR     = cw(0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 2'b00, 3'b000);
   localparam logic [15:0] C_EXI     = cw(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b10, 3'b000);
   localparam logic [15:0] C_WBI     = cw(0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 2'b00, 3'b000);
   localparam logic [15:0] C_ADDR    = cw(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b10, 3'b000);
   localparam logic [15:0] C_MRD     = cw(1, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 3'b000);
   localparam logic [15:0] C_WBM     = cw(0, 0, 0, 0, 0, 2'b00, 1, 0, 1, 0, 2'b00, 3'b000);
   localparam logic [15:0] C_MWR     = cw(0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 3'b000);
   localparam logic [15:0] C_BRT     = cw(0, 0, 0, 0, 1, 2'b01, 0, 0, 0, 1, 2'b00, 3'b001);
   localparam logic [15:0] C_BRN     = cw(0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 1, 2'b00, 3'b001);

   typedef struct {
      logic                rst_n;
      logic [3:0]          op;
      logic                zero;
      logic                rdy;
      logic [15:0]         cw;
      logic                halted;
      logic                illegal;
      logic                bus_err;
      logic [TB_CNT_W-1:0] cnt;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   logic [15:0] act_cw;
   assign act_cw = {mem_re, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst, mem_to_reg,
                    alu_src_a, alu_src_b, alu_op};

   task automatic v(input logic r, input logic [3:0] op, input logic z, input logic rdy,
                    input logic [15:0] c, input logic h, input logic il, input logic be,
                    input int cnt);
      vec_t t;
      t.rst_n = r; t.op = op; t.zero = z; t.rdy = rdy; t.cw = c;
      t.halted = h; t.illegal = il; t.bus_err = be; t.cnt = TB_CNT_W'(cnt);
      vecs.push_back(t);
   endtask

   // One R-type instruction with mem_ready=1: FETCH, DECODE, EXEC_R, WB_R.
   task automatic r_instr(input logic [3:0] op, input logic [15:0] exr, input logic il,
                          input int cnt);
      v(1, op, 0, 1, C_FRDY, 0, il, 0, cnt);
      v(1, op, 0, 1, C_DEC,  0, il, 0, cnt);
      v(1, op, 0, 1, exr,    0, il, 0, cnt);
      v(1, op, 0, 1, C_WBR,  0, il, 0, cnt);
   endtask

   task automatic build();
      v(0, 4'h0, 0, 0, C_ZERO, 0, 0, 0, 0);
      v(1, 4'h0, 0, 0, C_ZERO, 0, 0, 0, 0);
      r_instr(4'b0000, C_EXR_ADD, 0, 0);
      r_instr(4'b0001, C_EXR_SUB, 0, 1);
      r_instr(4'b0111, C_EXR_AND, 0, 2);
      // ADDI
      v(1, 4'b0011, 0, 1, C_FRDY, 0, 0, 0, 3);
      v(1, 4'b0011, 0, 1, C_DEC,  0, 0, 0, 3);
      v(1, 4'b0011, 0, 1, C_EXI,  0, 0, 0, 3);
      v(1, 4'b0011, 0, 1, C_WBI,  0, 0, 0, 3);
      // LW with three not-ready cycles in MEM_RD: 8 cycles total
      v(1, 4'b1000, 0, 1, C_FRDY, 0, 0, 0, 4);
      v(1, 4'b1000, 0, 1, C_DEC,  0, 0, 0, 4);
      v(1, 4'b1000, 0, 1, C_ADDR, 0, 0, 0, 4);
      for (int k = 0; k < 3; k++) v(1, 4'b1000, 0, 0, C_MRD, 0, 0, 0, 4);
      v(1, 4'b1000, 0, 1, C_MRD,  0, 0, 0, 4);
      v(1, 4'b1000, 0, 1, C_WBM,  0, 0, 0, 4);
      // SW
      v(1, 4'b1010, 0, 1, C_FRDY, 0, 0, 0, 5);
      v(1, 4'b1010, 0, 1, C_DEC,  0, 0, 0, 5);
      v(1, 4'b1010, 0, 1, C_ADDR, 0, 0, 0, 5);
      v(1, 4'b1010, 0, 1, C_MWR,  0, 0, 0, 5);
      // BEQ taken, then not taken (counter saturates at 7)
      v(1, 4'b1110, 1, 1, C_FRDY, 0, 0, 0, 6);
      v(1, 4'b1110, 1, 1, C_DEC,  0, 0, 0, 6);
      v(1, 4'b1110, 1, 1, C_BRT,  0, 0, 0, 6);
      v(1, 4'b1110, 0, 1, C_FRDY, 0, 0, 0, 7);
      v(1, 4'b1110, 0, 1, C_DEC,  0, 0, 0, 7);
      v(1, 4'b1110, 0, 1, C_BRN,  0, 0, 0, 7);
      // undefined opcode
      v(1, 4'b0101, 0, 1, C_FRDY, 0, 0, 0, 7);
      v(1, 4'b0101, 0, 1, C_DEC,  0, 0, 0, 7);
      // 14 not-ready FETCH cycles are tolerated
      for (int k = 0; k < 14; k++) v(1, 4'b0000, 0, 0, C_FWAIT, 0, 1, 0, 7);
      r_instr(4'b0000, C_EXR_ADD, 1, 7);
      // the 15th consecutive not-ready cycle times out into HALT
      for (int k = 0; k < 15; k++) v(1, 4'b0000, 0, 0, C_FWAIT, 0, 1, 0, 7);
      v(1, 4'b0000, 0, 1, C_ZERO, 1, 1, 1, 7);
      v(1, 4'b0000, 0, 1, C_ZERO, 1, 1, 1, 7);
      // reset, then HALT opcode
      v(0, 4'b1111, 0, 1, C_ZERO, 0, 0, 0, 0);
      v(1, 4'b1111, 0, 1, C_ZERO, 0, 0, 0, 0);
      v(1, 4'b1111, 0, 1, C_FRDY, 0, 0, 0, 0);
      v(1, 4'b1111, 0, 1, C_DEC,  0, 0, 0, 0);
      v(1, 4'b1111, 0, 1, C_ZERO, 1, 0, 0, 0);
      v(1, 4'b1111, 0, 1, C_ZERO, 1, 0, 0, 0);
      // reset, build up state, then reset mid-LW
      v(0, 4'b0000, 0, 1, C_ZERO, 0, 0, 0, 0);
      v(1, 4'b0000, 0, 1, C_ZERO, 0, 0, 0, 0);
      r_instr(4'b0000, C_EXR_ADD, 0, 0);
      v(1, 4'b0110, 0, 1, C_FRDY, 0, 0, 0, 1);
      v(1, 4'b0110, 0, 1, C_DEC,  0, 0, 0, 1);
      v(1, 4'b1000, 0, 1, C_FRDY, 0, 1, 0, 1);
      v(1, 4'b1000, 0, 1, C_DEC,  0, 1, 0, 1);
      v(1, 4'b1000, 0, 1, C_ADDR, 0, 1, 0, 1);
      v(1, 4'b1000, 0, 0, C_MRD,  0, 1, 0, 1);
      v(0, 4'b1000, 0, 0, C_ZERO, 0, 0, 0, 0);
      v(1, 4'b0000, 0, 0, C_ZERO, 0, 0, 0, 0);
      v(1, 4'b0000, 0, 0, C_FWAIT, 0, 0, 0, 0);
   endtask

   task automatic check(input int idx);
      vec_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (act_cw !== e.cw || halted !== e.halted || illegal !== e.illegal ||
          bus_err !== e.bus_err || instr_cnt !== e.cnt) begin
         n_miss++;
         $display("FAIL vec %0d: ctrl=%h halted=%b illegal=%b bus_err=%b cnt=%0d, expected ctrl=%h halted=%b illegal=%b bus_err=%b cnt=%0d",
                  idx, act_cw, halted, illegal, bus_err, instr_cnt,
                  e.cw, e.halted, e.illegal, e.bus_err, e.cnt);
      end
   endtask

   initial begin
      int n;
      rst_n = 1'b0; OPCODE = 4'h0; zero = 1'b0; mem_ready = 1'b0;
      build();
      foreach (vecs[i]) begin
         @(negedge clk);
         rst_n = vecs[i].rst_n; OPCODE = vecs[i].op;
         zero = vecs[i].zero;   mem_ready = vecs[i].rdy;
         exp_q.push_back(vecs[i]);
         #1;
         check(i);
      end

      // Timeout latency: bus_err must appear on the 16th cycle after reset release.
      @(negedge clk); rst_n = 1'b0; mem_ready = 1'b0; OPCODE = 4'h0;
      @(negedge clk); rst_n = 1'b1;
      n = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk); #1;
         if (bus_err === 1'b1) begin
            n = c;
            break;
         end
      end
      n_vec++;
      if (n != 16 || halted !== 1'b1) begin
         n_miss++;
         $display("FAIL timeout_latency: bus_err after %0d cycles halted=%b, expected 16 cycles halted=1",
                  n, halted);
      end

      // Late mem_ready must not leave HALT.
      mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_vec++;
      if (act_cw !== C_ZERO || halted !== 1'b1 || bus_err !== 1'b1 || instr_cnt !== '0) begin
         n_miss++;
         $display("FAIL halt_sticky: ctrl=%h halted=%b bus_err=%b cnt=%0d, expected ctrl=0000 halted=1 bus_err=1 cnt=0",
                  act_cw, halted, bus_err, instr_cnt);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
